// File: rtl/lane_pipe_reg_pkg.sv
// Shared definitions for the N-lane pipeline stage register: lane index
// type, entry source selector, kill-mask and lane slice helpers.
package lane_pipe_reg_pkg;

    localparam int MAX_LANES  = 32;
    localparam int LANE_IDX_W = $clog2(MAX_LANES);

    typedef logic [LANE_IDX_W-1:0] laneIdx_t;

    // Where an entry takes its next contents from at the coming edge
    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_UP   = 2'd1,
        SRC_SKID = 2'd2,
        SRC_NONE = 2'd3
    } entrySrc_e;

    // Kill mask: either the raw flush vector, or a prefix-OR so that a flush
    // in lane i also kills every younger lane j > i
    function automatic logic [MAX_LANES-1:0] killMask(
        input logic [MAX_LANES-1:0] flushVec,
        input logic                 younger
    );
        logic [MAX_LANES-1:0] k;
        logic                 acc;
        k   = '0;
        acc = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            acc  = acc | flushVec[i];
            k[i] = younger ? acc : flushVec[i];
        end
        return k;
    endfunction

    // Lowest bit of a lane's payload inside a packed group
    function automatic int laneLsb(input laneIdx_t lane, input int width);
        return int'(lane) * width;
    endfunction

endpackage

// File: rtl/lane_pipe_entry.sv
// One storage entry of the stage: a per-lane valid vector plus payload.
// The entry can hold, load a new group, or be cleared; the kill mask is
// applied on top of whichever of these happens.
module lane_pipe_entry
    import lane_pipe_reg_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_W     = 32,
    parameter int CLEAR_DATA = 1
) (
    input  logic                    clk_i,
    input  logic                    rstN_i,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic [LANES-1:0]        kill_i,
    input  logic [LANES-1:0]        valid_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic [LANES-1:0]        valid_o,
    output logic [LANES*DATA_W-1:0] data_o
);

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*DATA_W-1:0] data_q, data_d;

    // Pick the next contents, strip killed lanes and scrub dead lane payloads
    always_comb begin
        valid_d = clear_i ? '0 : (load_i ? valid_i : valid_q);
        valid_d = valid_d & ~kill_i;
        data_d  = load_i ? data_i : data_q;
        if (CLEAR_DATA != 0) begin
            for (int l = 0; l < LANES; l++) begin
                if (!valid_d[l]) begin
                    data_d[laneLsb(laneIdx_t'(l), DATA_W) +: DATA_W] = '0;
                end
            end
        end
    end

    // Entry storage with asynchronous discard of all contents
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/lane_pipe_reg.sv
// N-lane pipeline stage register with valid/ready handshake, one-entry skid
// buffer and per-lane flush. Head entry drives the downstream side; the
// skid catches the group accepted while the head is stalled.
module lane_pipe_reg
    import lane_pipe_reg_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int DATA_W        = 32,
    parameter int FLUSH_YOUNGER = 1,
    parameter int CLEAR_DATA    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        up_valid,
    input  logic [LANES*DATA_W-1:0] up_data,
    output logic                    up_ready,
    output logic [LANES-1:0]        dn_valid,
    output logic [LANES*DATA_W-1:0] dn_data,
    input  logic                    dn_ready,
    input  logic [LANES-1:0]        flush,
    output logic [1:0]              occupancy
);

    logic [LANES-1:0]        headValid, skidValid, killVec;
    logic [LANES*DATA_W-1:0] headData, skidData;
    logic                    headLive, skidLive, upFire, dnFire;
    entrySrc_e               headSrc, skidSrc;
    logic [LANES-1:0]        preHeadValid, preSkidValid;
    logic                    headLoad, headClear, skidLoad, skidClear;
    logic [LANES-1:0]        headInValid;
    logic [LANES*DATA_W-1:0] headInData;

    assign headLive  = |headValid;
    assign skidLive  = |skidValid;
    assign up_ready  = ~skidLive;
    assign upFire    = up_ready & (|up_valid);
    assign dnFire    = headLive & dn_ready;
    assign killVec   = LANES'(killMask(MAX_LANES'(flush), FLUSH_YOUNGER != 0));
    assign dn_valid  = headValid;
    assign dn_data   = headData;
    assign occupancy = {1'b0, headLive} + {1'b0, skidLive};

    // Choose entry sources: transfer first, then promote the skid if the
    // kill mask leaves the head dead while the younger group survives
    always_comb begin
        headSrc = SRC_HOLD;
        skidSrc = SRC_HOLD;
        if (dnFire) begin
            if (skidLive) begin
                headSrc = SRC_SKID;
                skidSrc = SRC_NONE;
            end else if (upFire) begin
                headSrc = SRC_UP;
            end else begin
                headSrc = SRC_NONE;
            end
        end else if (headLive) begin
            if (!skidLive && upFire) begin
                skidSrc = SRC_UP;
            end
        end else if (upFire) begin
            headSrc = SRC_UP;
        end

        case (headSrc)
            SRC_UP:   preHeadValid = up_valid;
            SRC_SKID: preHeadValid = skidValid;
            SRC_NONE: preHeadValid = '0;
            default:  preHeadValid = headValid;
        endcase
        case (skidSrc)
            SRC_UP:   preSkidValid = up_valid;
            SRC_NONE: preSkidValid = '0;
            default:  preSkidValid = skidValid;
        endcase

        if (!(|(preHeadValid & ~killVec)) && (|(preSkidValid & ~killVec))) begin
            headSrc = (skidSrc == SRC_UP) ? SRC_UP : SRC_SKID;
            skidSrc = SRC_NONE;
        end
    end

    // Turn the chosen sources into entry load/clear controls and head input
    always_comb begin
        headLoad    = (headSrc == SRC_UP) || (headSrc == SRC_SKID);
        headClear   = (headSrc == SRC_NONE);
        skidLoad    = (skidSrc == SRC_UP);
        skidClear   = (skidSrc == SRC_NONE);
        headInValid = up_valid;
        headInData  = up_data;
        if (headSrc == SRC_SKID) begin
            headInValid = skidValid;
            headInData  = skidData;
        end
    end

    lane_pipe_entry #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) uHead (
        .clk_i   (clk),
        .rstN_i  (rst),
        .load_i  (headLoad),
        .clear_i (headClear),
        .kill_i  (killVec),
        .valid_i (headInValid),
        .data_i  (headInData),
        .valid_o (headValid),
        .data_o  (headData)
    );

    lane_pipe_entry #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) uSkid (
        .clk_i   (clk),
        .rstN_i  (rst),
        .load_i  (skidLoad),
        .clear_i (skidClear),
        .kill_i  (killVec),
        .valid_i (up_valid),
        .data_i  (up_data),
        .valid_o (skidValid),
        .data_o  (skidData)
    );

endmodule

// File: tb/tb_lane_pipe_reg.sv
// Directed self-checking bench for lane_pipe_reg. Two instances share the
// stimulus: one kills younger lanes on flush, the other kills only the
// flushed lane.
module tb_lane_pipe_reg;

    logic        clock;
    logic        rst;
    logic [1:0]  upValid;
    logic [63:0] upData;
    logic        dnReady;
    logic [1:0]  flushVec;

    logic        upReady, nyUpReady;
    logic [1:0]  dnValid, nyDnValid;
    logic [63:0] dnData, nyDnData;
    logic [1:0]  occ, nyOcc;

    int vectorCount = 0;
    int missCount   = 0;

    lane_pipe_reg #(.LANES(2), .DATA_W(32), .FLUSH_YOUNGER(1), .CLEAR_DATA(1)) dut (
        .clk       (clock),
        .rst       (rst),
        .up_valid  (upValid),
        .up_data   (upData),
        .up_ready  (upReady),
        .dn_valid  (dnValid),
        .dn_data   (dnData),
        .dn_ready  (dnReady),
        .flush     (flushVec),
        .occupancy (occ)
    );

    lane_pipe_reg #(.LANES(2), .DATA_W(32), .FLUSH_YOUNGER(0), .CLEAR_DATA(1)) dutNy (
        .clk       (clock),
        .rst       (rst),
        .up_valid  (upValid),
        .up_data   (upData),
        .up_ready  (nyUpReady),
        .dn_valid  (nyDnValid),
        .dn_data   (nyDnData),
        .dn_ready  (dnReady),
        .flush     (flushVec),
        .occupancy (nyOcc)
    );

    // Free-running clock, 10 time units per cycle
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [1:0] uv, input logic [63:0] ud,
                                 input logic dr, input logic [1:0] fl);
        upValid  = uv;
        upData   = ud;
        dnReady  = dr;
        flushVec = fl;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Directed scenarios, each with hand-computed expectations
    initial begin
        rst = 1'b0;
        applyStimulus(2'b00, 64'h0, 1'b0, 2'b00);
        #12;
        checkOutput("rst_dn_valid", 64'(dnValid), 64'd0);
        checkOutput("rst_dn_data", dnData, 64'd0);
        checkOutput("rst_occ", 64'(occ), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_up_ready", 64'(upReady), 64'd1);

        // Single group passes straight through
        applyStimulus(2'b11, {32'hB, 32'hA}, 1'b1, 2'b00);
        stepClock();
        checkOutput("single_dn_valid", 64'(dnValid), 64'd3);
        checkOutput("single_dn_data", dnData, {32'hB, 32'hA});
        checkOutput("single_occ", 64'(occ), 64'd1);
        applyStimulus(2'b00, 64'h0, 1'b1, 2'b00);
        stepClock();
        checkOutput("single_drain_occ", 64'(occ), 64'd0);
        checkOutput("single_drain_valid", 64'(dnValid), 64'd0);

        // Backpressure: G1 to head, G2 to skid, G3 held upstream
        applyStimulus(2'b11, {32'h11, 32'h10}, 1'b0, 2'b00);
        stepClock();
        applyStimulus(2'b11, {32'h21, 32'h20}, 1'b0, 2'b00);
        stepClock();
        checkOutput("bp_occ_full", 64'(occ), 64'd2);
        applyStimulus(2'b11, {32'h31, 32'h30}, 1'b0, 2'b00);
        checkOutput("bp_up_ready_g3", 64'(upReady), 64'd0);
        stepClock();
        checkOutput("bp_hold_head", dnData, {32'h11, 32'h10});
        checkOutput("bp_hold_occ", 64'(occ), 64'd2);
        applyStimulus(2'b11, {32'h31, 32'h30}, 1'b1, 2'b00);
        checkOutput("bp_out_g1", dnData, {32'h11, 32'h10});
        stepClock();
        checkOutput("bp_out_g2", dnData, {32'h21, 32'h20});
        checkOutput("bp_up_ready_open", 64'(upReady), 64'd1);
        stepClock();
        applyStimulus(2'b00, 64'h0, 1'b1, 2'b00);
        checkOutput("bp_out_g3", dnData, {32'h31, 32'h30});
        checkOutput("bp_out_g3_valid", 64'(dnValid), 64'd3);
        stepClock();
        checkOutput("bp_drained_occ", 64'(occ), 64'd0);

        // Flush lane 0 with younger kill empties both entries
        applyStimulus(2'b11, {32'h41, 32'h40}, 1'b0, 2'b00);
        stepClock();
        applyStimulus(2'b11, {32'h51, 32'h50}, 1'b0, 2'b00);
        stepClock();
        applyStimulus(2'b00, 64'h0, 1'b0, 2'b01);
        stepClock();
        checkOutput("fy_occ", 64'(occ), 64'd0);
        checkOutput("fy_up_ready", 64'(upReady), 64'd1);
        checkOutput("fy_dn_data", dnData, 64'd0);
        checkOutput("fy_dn_valid", 64'(dnValid), 64'd0);

        // Flush lane 1 leaves lane 0 live, lane 1 payload zeroed
        pulseReset();
        applyStimulus(2'b11, {32'h61, 32'h60}, 1'b0, 2'b00);
        stepClock();
        applyStimulus(2'b00, 64'h0, 1'b0, 2'b10);
        stepClock();
        checkOutput("f1_dn_valid", 64'(dnValid), 64'd1);
        checkOutput("f1_dn_data", dnData, {32'h0, 32'h60});
        checkOutput("f1_occ", 64'(occ), 64'd1);

        // Delivery, new arrival and flush in one edge: flush hits only the new group
        applyStimulus(2'b11, {32'h91, 32'h90}, 1'b1, 2'b10);
        checkOutput("mix_delivered_valid", 64'(dnValid), 64'd1);
        stepClock();
        checkOutput("mix_new_valid", 64'(dnValid), 64'd1);
        checkOutput("mix_new_data", dnData, {32'h0, 32'h90});
        checkOutput("mix_occ", 64'(occ), 64'd1);

        // Head killed by a lane-only flush: skid promoted in the same edge
        pulseReset();
        applyStimulus(2'b01, {32'h0, 32'h70}, 1'b0, 2'b00);
        stepClock();
        applyStimulus(2'b11, {32'h81, 32'h80}, 1'b0, 2'b00);
        stepClock();
        checkOutput("promo_pre_occ", 64'(nyOcc), 64'd2);
        applyStimulus(2'b00, 64'h0, 1'b0, 2'b01);
        stepClock();
        checkOutput("promo_occ", 64'(nyOcc), 64'd1);
        checkOutput("promo_dn_valid", 64'(nyDnValid), 64'd2);
        checkOutput("promo_dn_data", nyDnData, {32'h81, 32'h0});
        checkOutput("promo_up_ready", 64'(nyUpReady), 64'd1);
        checkOutput("promo_fy_occ", 64'(occ), 64'd0);

        // Bubble while empty is never stored
        pulseReset();
        applyStimulus(2'b00, {32'hFF, 32'hFF}, 1'b0, 2'b00);
        stepClock();
        checkOutput("bubble_occ", 64'(occ), 64'd0);
        checkOutput("bubble_dn_valid", 64'(dnValid), 64'd0);
        checkOutput("bubble_up_ready", 64'(upReady), 64'd1);

        // Asynchronous reset in the middle of a full stall
        applyStimulus(2'b11, {32'hA1, 32'hA0}, 1'b0, 2'b00);
        stepClock();
        applyStimulus(2'b11, {32'hB1, 32'hB0}, 1'b0, 2'b00);
        stepClock();
        checkOutput("stall_occ", 64'(occ), 64'd2);
        rst = 1'b0;
        #1;
        checkOutput("arst_occ", 64'(occ), 64'd0);
        checkOutput("arst_dn_valid", 64'(dnValid), 64'd0);
        checkOutput("arst_dn_data", dnData, 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("arst_up_ready", 64'(upReady), 64'd1);
        applyStimulus(2'b00, 64'h0, 1'b1, 2'b00);
        stepClock();
        checkOutput("arst_after_occ", 64'(occ), 64'd0);
        checkOutput("arst_after_valid", 64'(dnValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
